rv_test_monitor: RTL
====================

Name: rv_test_monitor

Overview:
- Synthesizable run-control and end-of-test monitor for the pipelined core, instantiated beside `top` in simulation and on FPGA.
- Arms on a start pulse, counts cycles and retired instructions, and terminates the run on one of three events:
  - a write to the tohost address,
  - a hang (repeated self-loop retirement),
  - a timeout.
- Replaces fixed-duration runs with event-driven completion and latches a pass/fail verdict.

Parameters:
- ADDR_W, 32, width of data-memory address and retire PC
- CNT_W, 32, width of the cycle and retire counters
- TOHOST_ADDR, 32'h0000_1000, byte address whose write ends the test
- TIMEOUT_CYCLES, 100000, cycles after start before timeout; 0 disables timeout
- HANG_LIMIT, 16, consecutive retirements of the same PC that count as a hang; 0 disables hang detection

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: clear counters and enter RUN
- mem_we  in  1  data-memory write strobe from the MEM stage
- mem_addr  in  ADDR_W  data-memory write address
- mem_wdata  in  32  data-memory write data
- retire_valid  in  1  one instruction retired this cycle (WB stage)
- retire_pc  in  ADDR_W  PC of the retiring instruction
- busy  out  1  state is RUN
- done  out  1  state is DONE
- pass  out  1  valid when done; tohost value was 1
- hang  out  1  valid when done; run ended by hang
- timeout  out  1  valid when done; run ended by timeout
- fail_code  out  31  tohost value[31:1] on termination
- cycle_count  out  CNT_W  cycles elapsed in RUN
- retire_count  out  CNT_W  instructions retired in RUN

Behaviour:
- Reset is asynchronous and active-low: clk is the only clock; rst_n asserted low forces the state and all registers to reset immediately, independent of clk.
- Reset values: state IDLE; every output 0.
- All outputs are registered. No combinational path exists from any input to any output.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN.
  - On that edge, clear cycle_count, retire_count, the hang counter, last_pc, pass, hang, timeout and fail_code.
- RUN, on each edge:
  - cycle_count increments by 1, saturating at all-ones.
  - retire_count increments when retire_valid=1, saturating.
- Tohost event: mem_we=1 and mem_addr==TOHOST_ADDR and mem_wdata[0]==1.
  - -> DONE.
  - pass = (mem_wdata==32'h1).
  - fail_code = mem_wdata[31:1].
  - Tohost writes with mem_wdata[0]==0 are ignored.
- Hang event (HANG_LIMIT!=0):
  - On retire_valid, if retire_pc==last_pc then hcnt+1, else hcnt=1. last_pc is always updated.
  - hcnt is checked after the update. When it reaches HANG_LIMIT -> DONE, hang=1, pass=0.
  - The first retirement after start always sets hcnt=1.
- Timeout event (TIMEOUT_CYCLES!=0):
  - Fires when cycle_count==TIMEOUT_CYCLES-1 at an edge in RUN -> DONE, timeout=1, pass=0.
  - done therefore rises exactly TIMEOUT_CYCLES edges after the start edge.
- Same-edge priority: tohost > hang > timeout. Only the winning flag is set.
- Counters also update on the terminating edge, which includes the terminating retirement.
- DONE:
  - All outputs are frozen and done holds.
  - start=1 re-arms: same clearing as from IDLE, -> RUN.
  - Other inputs are ignored.
- start while in RUN: restart, i.e. counters and flags cleared, stay RUN. An event on the same edge is discarded.
- Reset mid-run: immediate return to IDLE with all outputs 0.
- mem_we, mem_addr and retire_valid are ignored in IDLE and DONE.

Test Plan:
- Reset then start; at cycle 40 write 32'h1 to 0x1000 -> done=1 on the next edge, pass=1, fail_code=0, cycle_count=41.
- Start; write 32'h7 to 0x1000 -> done=1, pass=0, fail_code=3; a later write of 32'h1 leaves the outputs unchanged.
- Start; retire PC 0x20 on 16 consecutive retirements (HANG_LIMIT=16), interleaved with idle cycles -> hang=1 after the 16th retirement, retire_count=16. With PC 0x24 inserted at the 10th retirement -> no hang until 16 more retirements of 0x20.
- TIMEOUT_CYCLES=50, no events -> done and timeout rise exactly 50 edges after start, cycle_count=50.
- Tohost pass write and the HANG_LIMIT-th self-loop retirement on the same edge -> pass=1, hang=0. Then pulse start -> busy=1, counters 0.
- Pull rst_n low mid-RUN between clock edges -> all outputs 0 immediately. Write 0x1000 with 32'h0 during a run -> ignored; run continues.

Source files
------------

// File: rtl/rv_test_monitor.sv
// rv_test_monitor: run-control and end-of-test monitor for the pipelined core.
// Arms on a start pulse, counts cycles and retirements, and ends the run on a
// tohost write, a self-loop hang or a timeout, latching the verdict.
module rv_test_monitor #(
   parameter int unsigned        ADDR_W         = 32,
   parameter int unsigned        CNT_W          = 32,
   parameter logic [ADDR_W-1:0]  TOHOST_ADDR    = ADDR_W'(32'h0000_1000),
   parameter int unsigned        TIMEOUT_CYCLES = 100000,
   parameter int unsigned        HANG_LIMIT     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic              retire_valid,
   input  logic [ADDR_W-1:0] retire_pc,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              hang,
   output logic              timeout,
   output logic [30:0]       fail_code,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  retire_count
);

   // Hang counter only needs to reach HANG_LIMIT; one spare code keeps it sane when disabled.
   localparam int unsigned        HCNT_W   = $clog2(HANG_LIMIT + 2);
   localparam bit                 HANG_EN  = (HANG_LIMIT != 0);
   localparam bit                 TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [HCNT_W-1:0]  HANG_CNT = HCNT_W'(HANG_LIMIT);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [HCNT_W-1:0]  HCNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic                hang_q, hang_d;
   logic                timeout_q, timeout_d;
   logic [30:0]         fail_code_q, fail_code_d;
   logic [CNT_W-1:0]    cycle_q, cycle_d;
   logic [CNT_W-1:0]    retire_q, retire_d;
   logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
   logic [ADDR_W-1:0]   last_pc_q, last_pc_d;

   logic                tohost_ev;
   logic                hang_ev;
   logic                to_ev;
   logic [HCNT_W-1:0]   hcnt_upd;

   // State register and all output/counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         hang_q      <= 1'b0;
         timeout_q   <= 1'b0;
         fail_code_q <= '0;
         cycle_q     <= '0;
         retire_q    <= '0;
         hcnt_q      <= '0;
         last_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         hang_q      <= hang_d;
         timeout_q   <= timeout_d;
         fail_code_q <= fail_code_d;
         cycle_q     <= cycle_d;
         retire_q    <= retire_d;
         hcnt_q      <= hcnt_d;
         last_pc_q   <= last_pc_d;
      end
   end

   // Next-state logic: counting and event arbitration in RUN, start clears from any state.
   always_comb begin
      state_d     = state_q;
      pass_d      = pass_q;
      hang_d      = hang_q;
      timeout_d   = timeout_q;
      fail_code_d = fail_code_q;
      cycle_d     = cycle_q;
      retire_d    = retire_q;
      hcnt_d      = hcnt_q;
      last_pc_d   = last_pc_q;

      // A zero count marks the first retirement since start.
      if (hcnt_q != '0 && retire_pc == last_pc_q) begin
         hcnt_upd = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HCNT_W'(1);
      end else begin
         hcnt_upd = HCNT_W'(1);
      end

      tohost_ev = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
      hang_ev   = HANG_EN && retire_valid && (hcnt_upd == HANG_CNT);
      to_ev     = TO_EN && (cycle_q == TO_LAST);

      case (state_q)
         ST_RUN: begin
            cycle_d = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
            if (retire_valid) begin
               retire_d  = (retire_q == CNT_MAX) ? retire_q : retire_q + CNT_W'(1);
               hcnt_d    = hcnt_upd;
               last_pc_d = retire_pc;
            end
            if (tohost_ev) begin
               state_d     = ST_DONE;
               pass_d      = (mem_wdata == 32'h1);
               fail_code_d = mem_wdata[31:1];
            end else if (hang_ev) begin
               state_d = ST_DONE;
               hang_d  = 1'b1;
               pass_d  = 1'b0;
            end else if (to_ev) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end
         end
         default: ;
      endcase

      // Start (re)arms from any state and discards any same-edge event.
      if (start) begin
         state_d     = ST_RUN;
         pass_d      = 1'b0;
         hang_d      = 1'b0;
         timeout_d   = 1'b0;
         fail_code_d = '0;
         cycle_d     = '0;
         retire_d    = '0;
         hcnt_d      = '0;
         last_pc_d   = '0;
      end

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign hang         = hang_q;
   assign timeout      = timeout_q;
   assign fail_code    = fail_code_q;
   assign cycle_count  = cycle_q;
   assign retire_count = retire_q;

endmodule
